ram_param: RTL and testbench

Parametrised synchronous successor to the 256x8 processor RAM. It keeps the sa/s/e command style: set the address register, store the input data, enable the output data. It adds a clock, configurable width and depth, auto-increment burst addressing, a registered output with a valid strobe, and a hardware clear sequencer that zeroes the array after reset or on request. It sits on the CPU data bus between the memory address register path and the bus multiplexer.

---
 rtl/ram_param.sv | 115 +++++++++++
 tb/tb_ram_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
// Parametrised synchronous RAM with sa/s/e command style, burst auto-increment,
// registered read port with valid strobe, and a hardware clear sequencer.
module ram_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a,
  input  logic              sa,
  input  logic              s,
  input  logic              e,
  input  logic              inc,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              d_valid_q, d_valid_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // The array has no reset; the clear sequencer defines its contents.
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mar_d     = mar_q;
    d_out_d   = '0;
    d_valid_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = mar_q;
    mem_wdata = d_in;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else begin
          // Accesses use the current MAR; any address update lands next cycle.
          if (s) begin
            mem_we = 1'b1;
          end
          if (e) begin
            d_out_d   = mem[mar_q];
            d_valid_d = 1'b1;
          end
          if (sa) begin
            mar_d = a;
          end else if (inc) begin
            mar_d = mar_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      mar_q     <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      mar_q     <= mar_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;
  assign busy    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: two instances (8x256 and 16x16) driven by
// directed and random commands, compared against an array-based reference model.
module tb_ram_param;

  logic        clk;
  logic        rst_n,  rst_nb;
  logic [7:0]  a;
  logic [3:0]  a_b;
  logic        sa, s, e, inc, clr;
  logic        sa_b, s_b, e_b, inc_b, clr_b;
  logic [7:0]  d_in,  d_out;
  logic [15:0] d_in_b, d_out_b;
  logic        d_valid, busy, d_valid_b, busy_b;

  int checks = 0;
  int errors = 0;

  // Reference model: one word array and one address per unit.
  logic [15:0] ref_mem [2][256];
  int          ref_mar [2];

  ram_param #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .sa(sa), .s(s), .e(e), .inc(inc),
    .clr(clr), .d_in(d_in), .d_out(d_out), .d_valid(d_valid), .busy(busy)
  );

  ram_param #(.DATA_W(16), .ADDR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_nb), .a(a_b), .sa(sa_b), .s(s_b), .e(e_b), .inc(inc_b),
    .clr(clr_b), .d_in(d_in_b), .d_out(d_out_b), .d_valid(d_valid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depthOf(input int u);
    return (u == 0) ? 256 : 16;
  endfunction

  function automatic logic [31:0] obsDout(input int u);
    return (u == 0) ? 32'(d_out) : 32'(d_out_b);
  endfunction

  function automatic logic obsValid(input int u);
    return (u == 0) ? d_valid : d_valid_b;
  endfunction

  function automatic logic obsBusy(input int u);
    return (u == 0) ? busy : busy_b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic driveInputs(input int u, input bit i_sa, input bit i_s, input bit i_e,
                             input bit i_inc, input bit i_clr, input int ai, input int di);
    if (u == 0) begin
      sa = i_sa; s = i_s; e = i_e; inc = i_inc; clr = i_clr;
      a = ai[7:0]; d_in = di[7:0];
    end else begin
      sa_b = i_sa; s_b = i_s; e_b = i_e; inc_b = i_inc; clr_b = i_clr;
      a_b = ai[3:0]; d_in_b = di[15:0];
    end
  endtask

  // One IDLE-state command cycle: predict, step one edge, compare.
  task automatic applyStimulus(input int u, input string tag, input bit i_sa, input bit i_s,
                               input bit i_e, input bit i_inc, input bit i_clr,
                               input int ai, input int di);
    int          depth = depthOf(u);
    int          dmask = (u == 0) ? 'hFF : 'hFFFF;
    logic [31:0] exp_do;
    logic        exp_dv;
    driveInputs(u, i_sa, i_s, i_e, i_inc, i_clr, ai, di);
    exp_dv = i_e && !i_clr;
    exp_do = exp_dv ? 32'(ref_mem[u][ref_mar[u]]) : 32'h0;
    if (i_clr) begin
      for (int k = 0; k < depth; k++) ref_mem[u][k] = '0;
    end else begin
      if (i_s) ref_mem[u][ref_mar[u]] = 16'(di & dmask);
      if (i_sa) ref_mar[u] = ai % depth;
      else if (i_inc) ref_mar[u] = (ref_mar[u] + 1) % depth;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".d_out"},   obsDout(u),         exp_do);
    checkOutput({tag, ".d_valid"}, 32'(obsValid(u)),   32'(exp_dv));
    checkOutput({tag, ".busy"},    32'(obsBusy(u)),    32'(i_clr));
  endtask

  // Runs through a clear with junk commands applied; they must all be ignored.
  task automatic waitClear(input int u, input string tag, input int expected_edges);
    int n = 0;
    driveInputs(u, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, int'($urandom), int'($urandom));
    do begin
      @(posedge clk);
      #1;
      n++;
      checkOutput({tag, ".dv_busy"}, 32'(obsValid(u)), 32'h0);
      checkOutput({tag, ".do_busy"}, obsDout(u),       32'h0);
    end while (obsBusy(u) && n < 1000);
    checkOutput({tag, ".edges"}, 32'(n), 32'(expected_edges));
    driveInputs(u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic pulseReset(input int u, input string tag);
    driveInputs(u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    if (u == 0) rst_n = 1'b0; else rst_nb = 1'b0;
    #1;
    checkOutput({tag, ".rst_d_out"},   obsDout(u),       32'h0);
    checkOutput({tag, ".rst_d_valid"}, 32'(obsValid(u)), 32'h0);
    checkOutput({tag, ".rst_busy"},    32'(obsBusy(u)),  32'h1);
    for (int k = 0; k < depthOf(u); k++) ref_mem[u][k] = '0;
    ref_mar[u] = 0;
    #2;
    if (u == 0) rst_n = 1'b1; else rst_nb = 1'b1;
  endtask

  task automatic randomSteps(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(u, "rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'b0, int'($urandom_range(0, depthOf(u) - 1)), int'($urandom));
    end
  endtask

  task automatic readSweep(input int u, input string tag);
    for (int i = 0; i < depthOf(u); i++) applyStimulus(u, tag, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(u, {tag, "_end"}, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic burstTest(input int u, input string tag, input int base, input int dw[4]);
    applyStimulus(u, {tag, "_sa"}, 1, 0, 0, 0, 0, base, 0);
    for (int i = 0; i < 4; i++) applyStimulus(u, {tag, "_wr"}, 0, 1, 0, 1, 0, 0, dw[i]);
    applyStimulus(u, {tag, "_sa2"}, 1, 0, 0, 0, 0, base, 0);
    for (int i = 0; i < 4; i++) applyStimulus(u, {tag, "_rd"}, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(u, {tag, "_end"}, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int bd8[4];
    int bd16[4];
    bd8  = '{'h11, 'h22, 'h33, 'h44};
    bd16 = '{'h1111, 'h2222, 'h3333, 'h4444};
    rst_n = 1'b0;
    rst_nb = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0);
    driveInputs(1, 0, 0, 0, 0, 0, 0, 0);
    ref_mar = '{0, 0};
    #7;

    $display("[TB] reset clear, 8x256");
    pulseReset(0, "t1");
    waitClear(0, "t1_clear", 256);
    readSweep(0, "t1_read");

    $display("[TB] fill and readback");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, "t2_sa", 1, 0, 0, 0, 0, i, 0);
      applyStimulus(0, "t2_wr", 0, 1, 0, 0, 0, 0, 255 - i);
    end
    for (int i = 0; i < 256; i++) applyStimulus(0, "t2_rd", 1, 0, 1, 0, 0, i, 0);
    applyStimulus(0, "t2_rd_last", 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, "t2_idle", 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] burst with wrap");
    burstTest(0, "t3", 'hFE, bd8);

    $display("[TB] simultaneous events");
    applyStimulus(0, "t4_sa", 1, 0, 0, 0, 0, 5, 0);
    applyStimulus(0, "t4_wr", 0, 1, 0, 0, 0, 0, 'hAA);
    applyStimulus(0, "t4_rbw", 0, 1, 1, 0, 0, 0, 'h55);
    applyStimulus(0, "t4_rd", 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, "t4_sainc", 1, 0, 0, 1, 0, 'h30, 0);
    applyStimulus(0, "t4_rd30", 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, "t4_sae", 1, 0, 1, 0, 0, 'h31, 0);
    applyStimulus(0, "t4_rd31", 0, 0, 1, 0, 0, 0, 0);

    randomSteps(0, 400);

    $display("[TB] reset mid-burst and clr");
    applyStimulus(0, "t5_sa", 1, 0, 0, 0, 0, 'h10, 0);
    applyStimulus(0, "t5_burst", 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, "t5_burst", 0, 0, 1, 1, 0, 0, 0);
    pulseReset(0, "t5");
    waitClear(0, "t5_clear", 256);
    readSweep(0, "t5_read");
    applyStimulus(0, "t5_sa40", 1, 0, 0, 0, 0, 'h40, 0);
    applyStimulus(0, "t5_wr", 0, 1, 0, 0, 0, 0, 'h99);
    applyStimulus(0, "t5_clr", 1, 1, 1, 1, 1, 'h80, 'h66);
    waitClear(0, "t5_clrwait", 256);
    applyStimulus(0, "t5_wr77", 0, 1, 0, 0, 0, 0, 'h77);
    applyStimulus(0, "t5_sa40b", 1, 0, 0, 0, 0, 'h40, 0);
    applyStimulus(0, "t5_rd77", 0, 0, 1, 0, 0, 0, 0);
    readSweep(0, "t5_read2");

    $display("[TB] parameter sweep, 16x16");
    pulseReset(1, "t6");
    waitClear(1, "t6_clear", 16);
    readSweep(1, "t6_read");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, "t6_sa", 1, 0, 0, 0, 0, i, 0);
      applyStimulus(1, "t6_wr", 0, 1, 0, 0, 0, 0, int'($urandom_range(0, 'hFFFF)));
    end
    for (int i = 0; i < 16; i++) applyStimulus(1, "t6_rd", 1, 0, 1, 0, 0, i, 0);
    applyStimulus(1, "t6_rd_last", 0, 0, 1, 0, 0, 0, 0);
    burstTest(1, "t6b", 'hE, bd16);
    randomSteps(1, 150);
    applyStimulus(1, "t6_clr", 0, 0, 0, 0, 1, 0, 0);
    waitClear(1, "t6_clrwait", 16);
    readSweep(1, "t6_read2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
